// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / hazard sequencer for the ARM 5-stage core.
// Shadows the EXE, MEM and WB destination state to drive operand selects, the ID stall and perf counters.
module fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [3:0]       id_dest,
  output logic             hazard_stall,
  output logic [1:0]       src1_sel,
  output logic [1:0]       src2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  // Shadow slots: _p0 = EXE, _p1 = MEM, _p2 = WB.
  // Source operands only matter in EXE, so later slots keep just the writer info.
  logic       vld_p0, vld_p1, vld_p2;
  logic       wb_p0, wb_p1, wb_p2;
  logic       mr_p0;
  logic       two_p0;
  logic [3:0] dest_p0, dest_p1, dest_p2;
  logic [3:0] src1_p0, src2_p0;

  logic raw_fwd, raw_nofwd, raw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic writer_hit(input logic vld, input logic wb,
                                      input logic [3:0] dest, input logic [3:0] src);
    return vld & wb & (dest == src);
  endfunction

  function automatic logic [1:0] fwd_select(input logic en, input logic [3:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (en) begin
      if (writer_hit(vld_p1, wb_p1, dest_p1, src))
        sel = 2'b01;
      else if (writer_hit(vld_p2, wb_p2, dest_p2, src))
        sel = 2'b10;
    end
    return sel;
  endfunction

  // EXE operand selects: decoded from registered slots only
  always_comb begin
    src1_sel = fwd_select(forward_en & vld_p0, src1_p0);
    src2_sel = fwd_select(forward_en & vld_p0 & two_p0, src2_p0);
  end

  // ID hazard detection; WB is never a hazard since the regfile writes before it is read
  always_comb begin
    raw_fwd   = mr_p0 &
                (writer_hit(vld_p0, wb_p0, dest_p0, id_src1) |
                 (id_two_src & writer_hit(vld_p0, wb_p0, dest_p0, id_src2)));
    raw_nofwd = writer_hit(vld_p0, wb_p0, dest_p0, id_src1) |
                writer_hit(vld_p1, wb_p1, dest_p1, id_src1) |
                (id_two_src & (writer_hit(vld_p0, wb_p0, dest_p0, id_src2) |
                               writer_hit(vld_p1, wb_p1, dest_p1, id_src2)));
    raw          = id_valid & (forward_en ? raw_fwd : raw_nofwd);
    hazard_stall = raw & ~flush;
  end

  // Control: slot valids and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!freeze) begin
      vld_p0 <= id_valid & ~flush & ~hazard_stall;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (hazard_stall)
        stall_cnt <= sat_inc(stall_cnt);
      if ((|src1_sel) | (|src2_sel))
        fwd_cnt <= sat_inc(fwd_cnt);
    end
  end

  // Data: slot payloads, qualified by the valids above
  always_ff @(posedge clk) begin
    if (!freeze) begin
      wb_p0   <= id_wb_en;
      mr_p0   <= id_mem_r_en;
      two_p0  <= id_two_src;
      dest_p0 <= id_dest;
      src1_p0 <= id_src1;
      src2_p0 <= id_src2;
      wb_p1   <= wb_p0;
      dest_p1 <= dest_p0;
      wb_p2   <= wb_p1;
      dest_p2 <= dest_p1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: a queue-of-slots reference model predicts
// each cycle's outputs, a negedge monitor pops and compares.
module tb_fwd_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, forward_en = 1'b1, freeze = 1'b0, flush = 1'b0;
  logic id_valid = 1'b0, id_two_src = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic [3:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic hazard_stall;
  logic [1:0] src1_sel, src2_sel;
  logic [CNT_W-1:0] stall_cnt, fwd_cnt;

  fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .hazard_stall(hazard_stall), .src1_sel(src1_sel), .src2_sel(src2_sel),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit wb; bit mr; bit two; bit [3:0] d, s1, s2; } slot_t;
  typedef struct { bit st; int s1; int s2; int sc; int fc; } exp_t;

  slot_t pipe[3];          // 0 = EXE, 1 = MEM, 2 = WB
  int    m_scnt, m_fcnt;
  exp_t  exp_q[$];
  int    n_cmp = 0, n_bad = 0;
  bit    last_stall = 0;

  // next-cycle stimulus
  bit n_rst = 1, n_fe = 1, n_frz = 0, n_fl = 0, n_idv = 0, n_two = 0, n_wb = 0, n_mr = 0;
  bit [3:0] n_s1 = 0, n_s2 = 0, n_d = 0;

  function automatic bit wr(slot_t s, bit [3:0] r);
    return s.v && s.wb && s.d == r;
  endfunction

  // youngest older writer wins: MEM -> 1, WB -> 2
  function automatic int m_sel(bit [3:0] r, bit gate);
    if (!forward_en || !pipe[0].v || !gate) return 0;
    for (int k = 1; k < 3; k++)
      if (wr(pipe[k], r)) return k;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit raw;
    raw = 0;
    if (id_valid) begin
      if (forward_en)
        raw = pipe[0].mr && (wr(pipe[0], id_src1) || (id_two_src && wr(pipe[0], id_src2)));
      else
        for (int k = 0; k < 2; k++)
          if (wr(pipe[k], id_src1) || (id_two_src && wr(pipe[k], id_src2))) raw = 1;
    end
    return raw && !flush;
  endfunction

  task automatic model_edge();
    bit st;
    int a, b;
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k].v = 0;
      m_scnt = 0;
      m_fcnt = 0;
    end else if (!freeze) begin
      st = m_stall();
      a  = m_sel(pipe[0].s1, 1'b1);
      b  = m_sel(pipe[0].s2, pipe[0].two);
      if (st && m_scnt < CMAX) m_scnt++;
      if ((a != 0 || b != 0) && m_fcnt < CMAX) m_fcnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{v: id_valid && !st && !flush, wb: id_wb_en, mr: id_mem_r_en,
                  two: id_two_src, d: id_dest, s1: id_src1, s2: id_src2};
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst = n_rst; forward_en = n_fe; freeze = n_frz; flush = n_fl;
    id_valid = n_idv; id_src1 = n_s1; id_src2 = n_s2; id_two_src = n_two;
    id_wb_en = n_wb; id_mem_r_en = n_mr; id_dest = n_d;
    e.st = m_stall();
    e.s1 = m_sel(pipe[0].s1, 1'b1);
    e.s2 = m_sel(pipe[0].s2, pipe[0].two);
    e.sc = m_scnt;
    e.fc = m_fcnt;
    last_stall = e.st;
    exp_q.push_back(e);
  endtask

  task automatic set_insn(bit v, bit [3:0] d, bit [3:0] s1, bit [3:0] s2, bit two, bit wb, bit mr);
    n_idv = v; n_d = d; n_s1 = s1; n_s2 = s2; n_two = two; n_wb = wb; n_mr = mr;
  endtask

  // present an instruction and hold it in ID while the stall is up
  task automatic issue(bit [3:0] d, bit [3:0] s1, bit [3:0] s2, bit two, bit wb, bit mr);
    set_insn(1, d, s1, s2, two, wb, mr);
    step();
    for (int k = 0; k < 20 && last_stall; k++) step();
  endtask

  task automatic idle(int n);
    set_insn(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hazard_stall", int'(hazard_stall), int'(e.st));
      chk("src1_sel", int'(src1_sel), e.s1);
      chk("src2_sel", int'(src2_sel), e.s2);
      chk("stall_cnt", int'(stall_cnt), e.sc);
      chk("fwd_cnt", int'(fwd_cnt), e.fc);
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    m_scnt = 0;
    m_fcnt = 0;
    // reset, then idle
    n_rst = 1; idle(2);
    n_rst = 0; idle(5);
    // forwarding: MEM then WB source
    n_fe = 1;
    issue(4'd1, 4'd2, 4'd3, 1, 1, 0);
    issue(4'd2, 4'd1, 4'd3, 1, 1, 0);
    issue(4'd6, 4'd1, 4'd7, 0, 1, 0);
    idle(3);
    // load-use in forward mode
    issue(4'd4, 4'd0, 4'd0, 0, 1, 1);
    issue(4'd5, 4'd4, 4'd4, 1, 1, 0);
    idle(3);
    // stall-only mode
    n_fe = 0;
    issue(4'd1, 4'd2, 4'd3, 1, 1, 0);
    issue(4'd8, 4'd1, 4'd9, 0, 1, 0);
    idle(3);
    // load-use under freeze
    n_fe = 1;
    issue(4'd4, 4'd0, 4'd0, 0, 1, 1);
    set_insn(1, 4'd5, 4'd4, 4'd4, 1, 1, 0);
    n_frz = 1;
    for (int k = 0; k < 3; k++) step();
    n_frz = 0;
    issue(4'd5, 4'd4, 4'd4, 1, 1, 0);
    idle(3);
    // flush over a raw hazard
    issue(4'd4, 4'd0, 4'd0, 0, 1, 1);
    n_fl = 1;
    set_insn(1, 4'd5, 4'd4, 4'd0, 0, 1, 0);
    step();
    n_fl = 0;
    idle(3);
    // reset mid-stream
    issue(4'd1, 4'd2, 4'd3, 0, 1, 0);
    issue(4'd2, 4'd1, 4'd1, 1, 1, 0);
    n_rst = 1; idle(1);
    n_rst = 0; idle(3);
    // randomized traffic on a small register set so hazards are frequent
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) n_fe = $urandom_range(0, 1);
      n_frz = ($urandom_range(0, 7) == 0);
      n_fl  = ($urandom_range(0, 9) == 0);
      n_rst = ($urandom_range(0, 399) == 0);
      if (!last_stall || n_fl)
        set_insn($urandom_range(0, 4) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0);
      step();
    end
    n_rst = 0; n_frz = 0; n_fl = 0;
    idle(2);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Pipeline sequencer for the ARM 5-stage core.
- Tracks the register-destination state of the instructions in EXE, MEM and WB in its own shadow pipeline.
- Drives the EXE-stage operand forwarding selects src1_sel/src2_sel and the ID-stage hazard stall.
- Honours memory freeze and branch flush, and keeps saturating performance counters for stalls and forwards.

Parameters:
CNT_W, 16, width of stall_cnt and fwd_cnt performance counters

Ports:
clk  in  1  core clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
forward_en  in  1  1 = forwarding mode, 0 = stall-only mode
freeze  in  1  memory-controller hold; entire shadow pipeline and counters hold
flush  in  1  taken branch resolved in EXE; ID instruction must not enter EXE
id_valid  in  1  ID holds a real instruction
id_src1  in  4  Rn of ID instruction
id_src2  in  4  Rm/Rd source of ID instruction
id_two_src  in  1  id_src2 is actually read
id_wb_en  in  1  ID instruction writes register file
id_mem_r_en  in  1  ID instruction is a load
id_dest  in  4  destination register of ID instruction
hazard_stall  out  1  hold IF/ID, inject bubble into EXE
src1_sel  out  2  EXE Val1 select: 00 regfile, 01 MEM_Val, 10 WB_Val
src2_sel  out  2  EXE Val_Rm select, same encoding
stall_cnt  out  CNT_W  cycles with hazard_stall=1 and freeze=0, saturating
fwd_cnt  out  CNT_W  unfrozen cycles where src1_sel or src2_sel is nonzero, saturating

Behaviour:
- Shadow slots EXE, MEM, WB. Each slot holds valid, wb_en, mem_r_en, dest[3:0], src1[3:0], src2[3:0], two_src.
- Reset: all slot valid=0, stall_cnt=0, fwd_cnt=0. Outputs follow: hazard_stall=0, src1_sel=src2_sel=00. Reset mid-stream discards all in-flight state.
- Advance rule on posedge when rst=0:
  - freeze=1: all slots and counters hold, regardless of flush or stall.
  - freeze=0: WB<=MEM, MEM<=EXE. EXE<=ID fields with valid=id_valid, unless flush=1 or hazard_stall=1, in which case EXE.valid<=0 (bubble).
- A slot counts as a writer only when valid=1 and wb_en=1.
- src1_sel (combinational decode of slot registers only, no input-to-output path):
  - Only when forward_en=1 and EXE.valid=1.
  - 01 if the MEM slot writer dest == EXE.src1.
  - Otherwise 10 if the WB slot writer dest == EXE.src1.
  - Otherwise 00.
  - MEM has priority over WB (youngest value wins).
- src2_sel: same rule on EXE.src2, additionally gated by EXE.two_src.
- forward_en=0: both selects are constant 00.
- raw hazard, forward_en=1 (load-use only): EXE is a writer with mem_r_en=1 and EXE.dest matches id_src1, or matches id_src2 with id_two_src=1.
- raw hazard, forward_en=0: any match of id_src1, or id_src2 with id_two_src=1, against the EXE or MEM writer dest. WB is excluded because the register file is write-before-read.
- raw is 0 when id_valid=0.
- hazard_stall = raw & ~flush. Flush dominates because the ID instruction is killed anyway.
- A load-use stall lasts exactly 1 cycle in forward mode. After the bubble the load sits in MEM and is forwarded via 01 on the next cycle.
- Counters increment by 1 on unfrozen cycles per their condition and stick at all-ones (2^CNT_W-1).
- Destination R15 gets no special treatment; branch redirect is handled by flush.

Test Plan:
- Reset then idle, id_valid=0 for 5 cycles -> hazard_stall=0, selects 00, counters 0.
- forward_en=1: ADD R1 issued, next ID SUB R2,R1,R3 -> 1 cycle later with SUB in EXE, src1_sel=01. Next insn reading R1 two behind -> src1_sel=10. fwd_cnt=2.
- forward_en=1: LDR R4 in EXE, ID ADD R5,R4,R4 two_src=1 -> hazard_stall=1 for exactly 1 cycle, bubble in EXE. Then ADD in EXE with src1_sel=src2_sel=01. stall_cnt=1.
- forward_en=0: ADD R1 in EXE, ID reads R1 -> hazard_stall=1 for 2 cycles (EXE then MEM), 0 once the writer reaches WB; selects stay 00.
- Load-use hazard with freeze=1 for 3 cycles -> slots and stall_cnt hold, hazard_stall stays 1. After freeze drops, one bubble inserted, stall_cnt=1.
- flush=1 with a raw hazard present -> hazard_stall=0 and EXE.valid=0 next cycle. Assert rst mid-stream -> next cycle all selects 00 and counters 0.
